controlador_contador: RTL and testbench

Command-driven sequencer for the cascaded 16-bit up/down/down-by-3/load counter (contador16 datapath). It accepts one command at a time over a valid/ready handshake and drives the counter's ENB, MODO and D inputs for an exact number of steps, optionally stopping early on RCO. When a command finishes, it reports the final count, the steps executed and the number of RCO pulses seen. It sits between the test/control logic and the counter array and is the only block that drives the counter's control inputs.

---
 rtl/controlador_contador_if.sv | 28 ++
 rtl/controlador_contador.sv | 142 ++++++++++++++
 tb/tb_controlador_contador.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_contador_if.sv
// Command/status bundle between a requester and the counter sequencer.
// The master issues commands and reads status; the slave is the sequencer.
interface controlador_contador_if #(
    parameter int unsigned ANCHO      = 16,
    parameter int unsigned PASOS_BITS = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_modo;
    logic [ANCHO-1:0]      cmd_dato;
    logic [PASOS_BITS-1:0] cmd_pasos;
    logic                  cmd_parar_rco;
    logic                  busy;
    logic                  done;
    logic [ANCHO-1:0]      resultado;
    logic [PASOS_BITS-1:0] pasos_hechos;
    logic [PASOS_BITS-1:0] n_rco;

    modport master (
        output cmd_valid, cmd_modo, cmd_dato, cmd_pasos, cmd_parar_rco,
        input  cmd_ready, busy, done, resultado, pasos_hechos, n_rco
    );

    modport slave (
        input  cmd_valid, cmd_modo, cmd_dato, cmd_pasos, cmd_parar_rco,
        output cmd_ready, busy, done, resultado, pasos_hechos, n_rco
    );
endinterface

// File: rtl/controlador_contador.sv
// Command sequencer for the 16-bit up/down/down-by-3/load counter: drives ENB/MODO/D
// for a fixed number of steps and reports final count, steps done and RCO pulses.
module controlador_contador #(
    parameter int unsigned ANCHO      = 16,
    parameter int unsigned PASOS_BITS = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_L,
    controlador_contador_if.slave  cmd_if,
    output logic                   enb_o,
    output logic [1:0]             modo_o,
    output logic [ANCHO-1:0]       d_o,
    input  logic [ANCHO-1:0]       q_i,
    input  logic                   rco_i
);

    typedef enum logic [2:0] {StIdle, StCarga, StCuenta, StEspera, StHecho} estado_e;

    localparam logic [1:0] ModoCarga = 2'b11;

    estado_e               state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  enb_q, enb_d;
    logic [1:0]            modo_q, modo_d;
    logic [ANCHO-1:0]      d_q, d_d;
    logic                  parar_q, parar_d;
    logic [PASOS_BITS-1:0] rest_q, rest_d;
    logic [ANCHO-1:0]      resultado_q, resultado_d;
    logic [PASOS_BITS-1:0] pasos_hechos_q, pasos_hechos_d;
    logic [PASOS_BITS-1:0] n_rco_q, n_rco_d;

    always_comb begin
        state_d        = state_q;
        ready_d        = ready_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        enb_d          = enb_q;
        modo_d         = modo_q;
        d_d            = d_q;
        parar_d        = parar_q;
        rest_d         = rest_q;
        resultado_d    = resultado_q;
        pasos_hechos_d = pasos_hechos_q;
        n_rco_d        = n_rco_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_if.cmd_valid && ready_q) begin
                    ready_d        = 1'b0;
                    busy_d         = 1'b1;
                    parar_d        = cmd_if.cmd_parar_rco;
                    rest_d         = cmd_if.cmd_pasos;
                    pasos_hechos_d = '0;
                    n_rco_d        = '0;
                    if (cmd_if.cmd_modo == ModoCarga) begin
                        state_d = StCarga;
                        enb_d   = 1'b1;
                        modo_d  = ModoCarga;
                        d_d     = cmd_if.cmd_dato;
                    end else if (cmd_if.cmd_pasos == '0) begin
                        state_d = StEspera;
                    end else begin
                        state_d = StCuenta;
                        enb_d   = 1'b1;
                        modo_d  = cmd_if.cmd_modo;
                    end
                end
            end
            StCarga: begin
                enb_d          = 1'b0;
                pasos_hechos_d = PASOS_BITS'(1);
                state_d        = StEspera;
            end
            StCuenta: begin
                pasos_hechos_d = pasos_hechos_q + PASOS_BITS'(1);
                rest_d         = rest_q - PASOS_BITS'(1);
                if (rco_i && (n_rco_q != '1)) begin
                    n_rco_d = n_rco_q + PASOS_BITS'(1);
                end
                // The step with RCO high still counts; enable drops on the next cycle.
                if ((rest_q == PASOS_BITS'(1)) || (parar_q && rco_i)) begin
                    enb_d   = 1'b0;
                    state_d = StEspera;
                end
            end
            StEspera: begin
                resultado_d = q_i;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = StHecho;
            end
            StHecho: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q        <= StIdle;
            ready_q        <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            enb_q          <= 1'b0;
            modo_q         <= 2'b00;
            d_q            <= '0;
            parar_q        <= 1'b0;
            rest_q         <= '0;
            resultado_q    <= '0;
            pasos_hechos_q <= '0;
            n_rco_q        <= '0;
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            enb_q          <= enb_d;
            modo_q         <= modo_d;
            d_q            <= d_d;
            parar_q        <= parar_d;
            rest_q         <= rest_d;
            resultado_q    <= resultado_d;
            pasos_hechos_q <= pasos_hechos_d;
            n_rco_q        <= n_rco_d;
        end
    end

    assign cmd_if.cmd_ready    = ready_q;
    assign cmd_if.busy         = busy_q;
    assign cmd_if.done         = done_q;
    assign cmd_if.resultado    = resultado_q;
    assign cmd_if.pasos_hechos = pasos_hechos_q;
    assign cmd_if.n_rco        = n_rco_q;
    assign enb_o               = enb_q;
    assign modo_o              = modo_q;
    assign d_o                 = d_q;

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador driving a behavioural 16-bit counter model.
module tb_controlador_contador;

    logic        clk;
    logic        rst_n;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] d;
    logic [15:0] q;
    logic        rco;

    int n_checks = 0;
    int n_errors = 0;

    controlador_contador_if #(.ANCHO(16), .PASOS_BITS(8)) cmd_if ();

    controlador_contador #(.ANCHO(16), .PASOS_BITS(8)) dut (
        .CLK     (clk),
        .RESET_L (rst_n),
        .cmd_if  (cmd_if),
        .enb_o   (enb),
        .modo_o  (modo),
        .d_o     (d),
        .q_i     (q),
        .rco_i   (rco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: RCO is registered from the pre-update Q.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 16'h0000;
            rco <= 1'b0;
        end else if (enb) begin
            case (modo)
                2'b00: begin q <= q + 16'd1; rco <= (q == 16'hFFFF); end
                2'b01: begin q <= q - 16'd1; rco <= (q == 16'h0000); end
                2'b10: begin q <= q - 16'd3; rco <= (q < 16'd3);     end
                default: begin q <= d; rco <= 1'b0; end
            endcase
        end else begin
            rco <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to DONE, measuring enable cycles and latency.
    task automatic run_cmd(input logic [1:0] c_modo, input logic [15:0] c_dato,
                           input logic [7:0] c_pasos, input logic c_parar,
                           output int n_enb, output int lat,
                           output logic [1:0] modo_seen, output logic [15:0] d_seen);
        bit accepted = 0;
        bit got_done = 0;
        n_enb = 0;
        lat = 0;
        modo_seen = 2'b00;
        d_seen = 16'h0;
        @(negedge clk);
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_modo      = c_modo;
        cmd_if.cmd_dato      = c_dato;
        cmd_if.cmd_pasos     = c_pasos;
        cmd_if.cmd_parar_rco = c_parar;
        for (int i = 0; i < 20; i++) begin
            if (cmd_if.cmd_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("accepted", 32'(accepted), 32'd1);
        for (int i = 0; i < 300 && accepted; i++) begin
            @(negedge clk);
            cmd_if.cmd_valid = 1'b0;
            lat++;
            if (enb) begin
                n_enb++;
                modo_seen = modo;
                d_seen = d;
            end
            if (cmd_if.done) begin
                got_done = 1;
                break;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        check_eq("done_seen", 32'(got_done), 32'd1);
    endtask

    int          n_enb;
    int          lat;
    logic [1:0]  modo_seen;
    logic [15:0] d_seen;

    initial begin
        bit enb_seen;
        bit got_done;
        rst_n = 1'b0;
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_modo      = 2'b00;
        cmd_if.cmd_dato      = 16'h0;
        cmd_if.cmd_pasos     = 8'h0;
        cmd_if.cmd_parar_rco = 1'b0;
        #12;
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check_eq("rst_enb", 32'(enb), 32'd0);
        check_eq("rst_busy", 32'(cmd_if.busy), 32'd0);
        check_eq("rst_done", 32'(cmd_if.done), 32'd0);
        check_eq("rst_res", 32'(cmd_if.resultado), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Parallel load
        run_cmd(2'b11, 16'h1234, 8'd0, 1'b0, n_enb, lat, modo_seen, d_seen);
        check_eq("load_enb", 32'(n_enb), 32'd1);
        check_eq("load_modo", 32'(modo_seen), 32'd3);
        check_eq("load_d", 32'(d_seen), 32'h1234);
        check_eq("load_lat", 32'(lat), 32'd3);
        check_eq("load_res", 32'(cmd_if.resultado), 32'h1234);
        check_eq("load_ph", 32'(cmd_if.pasos_hechos), 32'd1);

        // Up 5 from 0x00FE
        run_cmd(2'b11, 16'h00FE, 8'd0, 1'b0, n_enb, lat, modo_seen, d_seen);
        run_cmd(2'b00, 16'h0, 8'd5, 1'b0, n_enb, lat, modo_seen, d_seen);
        check_eq("up_enb", 32'(n_enb), 32'd5);
        check_eq("up_lat", 32'(lat), 32'd7);
        check_eq("up_modo", 32'(modo_seen), 32'd0);
        check_eq("up_res", 32'(cmd_if.resultado), 32'h0103);
        check_eq("up_ph", 32'(cmd_if.pasos_hechos), 32'd5);
        check_eq("up_nrco", 32'(cmd_if.n_rco), 32'd0);

        // Down by 3 through zero
        run_cmd(2'b11, 16'h0005, 8'd0, 1'b0, n_enb, lat, modo_seen, d_seen);
        run_cmd(2'b10, 16'h0, 8'd4, 1'b0, n_enb, lat, modo_seen, d_seen);
        check_eq("d3_enb", 32'(n_enb), 32'd4);
        check_eq("d3_modo", 32'(modo_seen), 32'd2);
        check_eq("d3_res", 32'(cmd_if.resultado), 32'hFFF9);
        check_eq("d3_ph", 32'(cmd_if.pasos_hechos), 32'd4);
        check_eq("d3_nrco", 32'(cmd_if.n_rco), 32'd1);

        // Up with early stop on RCO
        run_cmd(2'b11, 16'hFFFD, 8'd0, 1'b0, n_enb, lat, modo_seen, d_seen);
        run_cmd(2'b00, 16'h0, 8'd10, 1'b1, n_enb, lat, modo_seen, d_seen);
        check_eq("stop_enb", 32'(n_enb), 32'd4);
        check_eq("stop_lat", 32'(lat), 32'd6);
        check_eq("stop_res", 32'(cmd_if.resultado), 32'h0001);
        check_eq("stop_ph", 32'(cmd_if.pasos_hechos), 32'd4);
        check_eq("stop_nrco", 32'(cmd_if.n_rco), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("hold_res", 32'(cmd_if.resultado), 32'h0001);

        // Zero steps with a second command held on the bus
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_modo  = 2'b00;
        cmd_if.cmd_pasos = 8'd0;
        cmd_if.cmd_parar_rco = 1'b0;
        check_eq("z_ready", 32'(cmd_if.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_modo = 2'b11;
        cmd_if.cmd_dato = 16'hABCD;
        enb_seen = 0;
        got_done = 0;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (enb) enb_seen = 1;
            if (cmd_if.done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check_eq("z_done", 32'(got_done), 32'd1);
        check_eq("z_lat", 32'(lat), 32'd2);
        check_eq("z_enb", 32'(enb_seen), 32'd0);
        check_eq("z_res", 32'(cmd_if.resultado), 32'h0001);
        check_eq("z_ph", 32'(cmd_if.pasos_hechos), 32'd0);
        check_eq("z_rdy_done", 32'(cmd_if.cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("z_rdy_after", 32'(cmd_if.cmd_ready), 32'd1);
        check_eq("z_busy_after", 32'(cmd_if.busy), 32'd0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check_eq("z2_busy", 32'(cmd_if.busy), 32'd1);
        check_eq("z2_enb", 32'(enb), 32'd1);
        check_eq("z2_d", 32'(d), 32'hABCD);
        got_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_if.done) begin
                got_done = 1;
                break;
            end
        end
        check_eq("z2_done", 32'(got_done), 32'd1);
        check_eq("z2_res", 32'(cmd_if.resultado), 32'hABCD);

        // Asynchronous reset in the middle of counting
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_modo  = 2'b00;
        cmd_if.cmd_pasos = 8'd100;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_enb", 32'(enb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_enb", 32'(enb), 32'd0);
        check_eq("arst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check_eq("arst_busy", 32'(cmd_if.busy), 32'd0);
        check_eq("arst_done", 32'(cmd_if.done), 32'd0);
        check_eq("arst_res", 32'(cmd_if.resultado), 32'd0);
        check_eq("arst_ph", 32'(cmd_if.pasos_hechos), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
